// File: rtl/rptr_empty_fwft.sv
// Read-side FIFO pointer/empty logic with a first-word-fall-through output register; rvalid rises 2 rclk edges after new data appears.
// A held word stalls the pointers until rinc. Define RPTR_UNDERFLOW_CHK_EN to build the sticky pop-while-empty error flag.
module rptr_empty_fwft #(
    parameter int ADDRSIZE      = 3,
    parameter int DSIZE         = 8,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DSIZE-1:0]    rmem_data,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DSIZE-1:0]    rdata,
    output logic                rvalid,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                raempty,
    output logic                rerr_uflow
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    localparam logic [ADDRSIZE:0] AE_TH = (ADDRSIZE+1)'(AEMPTY_THRESH);

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    state_t            state_q, state_d;
    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0] rlevel_q, rlevel_d;
    logic [DSIZE-1:0]  rdata_q, rdata_d;
    logic              rempty_q, rempty_d;
    logic              raempty_q, raempty_d;
    logic              ren;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        ren     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (!rempty_q) begin
                    ren     = 1'b1;
                    rdata_d = rmem_data;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // A pop with memory still non-empty refills in the same edge: no bubble.
                if (rinc) begin
                    if (!rempty_q) begin
                        ren     = 1'b1;
                        rdata_d = rmem_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
        endcase

        rbin_d    = rbin_q + {{ADDRSIZE{1'b0}}, ren};
        rptr_d    = (rbin_d >> 1) ^ rbin_d;
        rempty_d  = (rptr_d == rq2_wptr);
        // Words still in memory plus the one parked in rdata.
        rlevel_d  = gray2bin(rq2_wptr) - rbin_d + {{ADDRSIZE{1'b0}}, (state_d == ST_VALID)};
        raempty_d = (rlevel_d <= AE_TH);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q   <= ST_EMPTY;
            rbin_q    <= '0;
            rptr_q    <= '0;
            rdata_q   <= '0;
            rempty_q  <= 1'b1;
            rlevel_q  <= '0;
            raempty_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rdata_q   <= rdata_d;
            rempty_q  <= rempty_d;
            rlevel_q  <= rlevel_d;
            raempty_q <= raempty_d;
        end
    end

`ifdef RPTR_UNDERFLOW_CHK_EN
    logic uflow_q, uflow_d;

    always_comb begin
        uflow_d = uflow_q | (rinc & (state_q != ST_VALID));
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            uflow_q <= 1'b0;
        end else begin
            uflow_q <= uflow_d;
        end
    end

    assign rerr_uflow = uflow_q;
`else
    assign rerr_uflow = 1'b0;
`endif

    assign raddr   = rbin_q[ADDRSIZE-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign rdata   = rdata_q;
    assign rvalid  = (state_q == ST_VALID);
    assign rlevel  = rlevel_q;
    assign raempty = raempty_q;

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Scoreboard bench: writer model feeds memory and expected-data queue; a negedge monitor checks pops, level and pointer invariants.
module tb_rptr_empty_fwft;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rinc;
    logic [AW:0]   rq2_wptr;
    logic [DW-1:0] rmem_data;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic [AW:0]   rlevel;
    logic          raempty;
    logic          rerr_uflow;

    logic [DW-1:0] mem [8];
    logic [DW-1:0] exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            wcnt = 0;
    int            popcnt = 0;
    int            prev_wcnt = 0;
    int            lvl;
    bit            rst_prev = 1'b1;
    bit            uf_exp = 1'b0;
    bit            uf_on;
    logic [AW:0]   last_rptr = '0;
    logic [AW:0]   fetched;

    rptr_empty_fwft #(.ADDRSIZE(AW), .DSIZE(DW), .AEMPTY_THRESH(1)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .rmem_data  (rmem_data),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rlevel     (rlevel),
        .raempty    (raempty),
        .rerr_uflow (rerr_uflow)
    );

    always #5 rclk = ~rclk;
    assign rmem_data = mem[raddr];

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wcnt % 8] = d;
        wcnt++;
        exp_q.push_back(d);
        rq2_wptr = bin2gray(4'(wcnt));
    endtask

    task automatic do_reset(input int n, input logic inc);
        rrst_n   = 1'b0;
        rinc     = inc;
        wcnt     = 0;
        exp_q.delete();
        rq2_wptr = '0;
        repeat (n) tick();
        rrst_n = 1'b1;
        rinc   = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rptr"}, rptr, 0);
        chk({tag, "_raddr"}, raddr, 0);
        chk({tag, "_rempty"}, rempty, 1);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rlevel"}, rlevel, 0);
        chk({tag, "_raempty"}, raempty, 1);
        chk({tag, "_uflow"}, rerr_uflow, 0);
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!rvalid && t < 8) begin
            tick();
            t++;
        end
        chk({tag, "_wait_valid"}, rvalid, 1);
    endtask

    // Monitor: outputs observed here reflect the edge just passed; pops decided here happen at the next edge.
    always @(negedge rclk) begin
        if (rst_prev) begin
            chk("mon_rst_rlevel", rlevel, 0);
            chk("mon_rst_rvalid", rvalid, 0);
            chk("mon_rst_rptr", rptr, 0);
            chk("mon_rst_rempty", rempty, 1);
            chk("mon_rst_raempty", raempty, 1);
            chk("mon_rst_rdata", rdata, 0);
        end else begin
            lvl     = prev_wcnt - popcnt;
            fetched = 4'(popcnt + int'(rvalid));
            chk("mon_rlevel", rlevel, lvl);
            chk("mon_raempty", raempty, lvl <= 1);
            chk("mon_rptr_bin", gray2bin(rptr), fetched);
            chk("mon_rempty", rempty, fetched == 4'(prev_wcnt));
            chk("mon_raddr", raddr, fetched[AW-1:0]);
            chk("mon_gray_step", $countones(rptr ^ last_rptr) <= 1, 1);
        end
        chk("mon_uflow", rerr_uflow, uf_exp);
        rst_prev = !rrst_n;
        if (!rrst_n) begin
            popcnt = 0;
            uf_exp = 1'b0;
        end else begin
            if (rinc && rvalid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_pop actual=%0h required=no_word_pending", rdata);
                end else begin
                    chk("sb_rdata", rdata, exp_q.pop_front());
                end
                popcnt++;
            end
            if (rinc && !rvalid && uf_on) uf_exp = 1'b1;
        end
        prev_wcnt = wcnt;
        last_rptr = rptr;
    end

    initial begin
`ifdef RPTR_UNDERFLOW_CHK_EN
        uf_on = 1'b1;
`else
        uf_on = 1'b0;
`endif
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // Reset held 2 edges with rinc asserted
        do_reset(2, 1'b1);
        chk_reset("r033");

        // Single word, first-word-fall-through latency
        tick();
        write_word(8'hA5);
        tick();
        chk("r034_rempty0", rempty, 0);
        chk("r034_rvalid0", rvalid, 0);
        tick();
        chk("r034_rvalid", rvalid, 1);
        chk("r034_rdata", rdata, 8'hA5);
        chk("r034_rptr", rptr, 4'b0001);
        chk("r034_rempty1", rempty, 1);
        chk("r034_rlevel", rlevel, 1);

        // Pop it, then pop again while empty
        rinc = 1'b1;
        tick();
        chk("r036_drained", rvalid, 0);
        tick();
        chk("r036_rptr", rptr, 4'b0001);
        chk("r036_rdata", rdata, 8'hA5);
        chk("r036_uflow", rerr_uflow, uf_on);
        rinc = 1'b0;
        tick();
        chk("r036_uflow_sticky", rerr_uflow, uf_on);

        // Full memory streamed back-to-back with rinc held
        do_reset(1, 1'b0);
        for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
        rinc = 1'b1;
        wait_valid("r035");
        for (int k = 0; k < 8; k++) begin
            chk("r035_rdata", rdata, 8'h10 + k);
            chk("r035_raddr", raddr, (k + 1) % 8);
            chk("r035_rvalid", rvalid, 1);
            tick();
        end
        chk("r035_end_rvalid", rvalid, 0);
        chk("r035_end_rptr", rptr, 4'b1100);
        chk("r035_end_rempty", rempty, 1);
        chk("r035_end_rlevel", rlevel, 0);
        rinc = 1'b0;

        // Level and almost-empty while draining 3 words slowly
        do_reset(1, 1'b0);
        for (int i = 0; i < 3; i++) write_word(8'(8'h30 + i));
        wait_valid("r037");
        chk("r037_lvl3", rlevel, 3);
        chk("r037_ae3", raempty, 0);
        for (int k = 2; k >= 0; k--) begin
            rinc = 1'b1;
            tick();
            rinc = 1'b0;
            chk("r037_lvl", rlevel, k);
            chk("r037_ae", raempty, k <= 1);
            tick();
        end

        // Reset in the middle of a stream, then resume from zero
        do_reset(1, 1'b0);
        for (int i = 0; i < 7; i++) write_word(8'(8'h50 + i));
        wait_valid("r038");
        rinc = 1'b1;
        tick();
        tick();
        chk("r038_lvl5", rlevel, 5);
        do_reset(1, 1'b1);
        chk_reset("r038");
        write_word(8'h77);
        write_word(8'h78);
        wait_valid("r038_resume");
        chk("r038_resume_rptr", rptr, 4'b0001);
        chk("r038_resume_rdata", rdata, 8'h77);
        rinc = 1'b1;
        repeat (3) tick();
        rinc = 1'b0;
        chk("r038_resume_empty", rvalid, 0);

        // Randomized traffic with alternating consumer speed
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 1 && (wcnt - popcnt) < 8) write_word(8'($urandom));
            rinc = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 85 : 30));
            tick();
        end

        // Drain and confirm everything written came back
        rinc = 1'b1;
        for (int t = 0; t < 30 && (exp_q.size() != 0 || rvalid); t++) tick();
        rinc = 1'b0;
        tick();
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_rvalid", rvalid, 0);
        chk("drain_rlevel", rlevel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rptr_empty_fwft.md
RPTR_EMPTY_FWFT -- requirements
Module: rptr_empty_fwft

Interface
REQ-001 Parameter ADDRSIZE, default 3, memory address width; FIFO depth 2^ADDRSIZE.
REQ-002 Parameter DSIZE, default 8, data word width.
REQ-003 Parameter AEMPTY_THRESH, default 1, almost-empty level threshold.
REQ-004 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rrst_n  input  1  reset, synchronous to rclk, active-low.
REQ-006 rinc  input  1  consumer pop; accepted only when rvalid=1.
REQ-007 rq2_wptr  input  ADDRSIZE+1  Gray write pointer, already two-flop synchronized into rclk.
REQ-008 rmem_data  input  DSIZE  combinational memory read data, mem[raddr].
REQ-009 raddr  output  ADDRSIZE  binary memory read address, rbin[ADDRSIZE-1:0].
REQ-010 rptr  output  ADDRSIZE+1  registered Gray read pointer, to be synchronized by the write domain.
REQ-011 rempty  output  1  registered memory-side empty flag.
REQ-012 rdata  output  DSIZE  first-word-fall-through output register.
REQ-013 rvalid  output  1  rdata holds an unread word.
REQ-014 rlevel  output  ADDRSIZE+1  registered word count: unfetched memory words plus rvalid.
REQ-015 raempty  output  1  registered almost-empty flag.
REQ-016 rerr_uflow  output  1  sticky underflow error.

Function
REQ-017 Internal fetch: ren = ~rempty & (~rvalid | rinc); rbinnext = rbin + ren; rgraynext = (rbinnext>>1) ^ rbinnext; rbin and rptr load rbinnext and rgraynext every edge.
REQ-018 rempty SHALL load (rgraynext == rq2_wptr) every edge.
REQ-019 The FSM SHALL have two states: EMPTY (rvalid=0) and VALID (rvalid=1).
REQ-020 EMPTY: if rempty=0, fetch; rdata <= rmem_data; go to VALID. Otherwise remain in EMPTY.
REQ-021 VALID with rinc=1 and rempty=0: fetch; rdata <= rmem_data; remain in VALID. This gives one word per cycle with no bubble.
REQ-022 VALID with rinc=1 and rempty=1: go to EMPTY; rdata holds its last value.
REQ-023 VALID with rinc=0: hold rdata and the pointers.
REQ-024 rinc while EMPTY SHALL be ignored: no pointer, rdata or state change.
REQ-025 Latency: rvalid SHALL rise 2 rclk edges after the first edge at which rq2_wptr differs from rptr.
REQ-026 Pointer arithmetic is modulo 2^(ADDRSIZE+1). raddr wraps 2^ADDRSIZE-1 -> 0. The pointer MSB toggles each wrap.
REQ-027 rlevel SHALL load (gray2bin(rq2_wptr) - rbinnext) mod 2^(ADDRSIZE+1) + next rvalid.
REQ-028 raempty SHALL load (next rlevel <= AEMPTY_THRESH).
REQ-029 rptr SHALL change by at most one Gray bit per edge.

Reset
REQ-030 While rrst_n=0 at a rising edge, the block SHALL load these values, overriding all other inputs including a mid-stream rinc:
- rbin=0, rptr=0, raddr=0
- rempty=1, rvalid=0 (state EMPTY), rdata=0
- rlevel=0, raempty=1, rerr_uflow=0
REQ-031 No output SHALL change asynchronously to rclk.

Configuration
REQ-032 Macro RPTR_UNDERFLOW_CHK_EN.
- Defined: rerr_uflow sets when rinc=1 while rvalid=0, and stays 1 until reset.
- Undefined: rerr_uflow is constant 0 and no checking logic is built.
- The port exists in both builds.

Verification (ADDRSIZE=3, DSIZE=8, AEMPTY_THRESH=1)
REQ-033 Hold rrst_n=0 for 2 edges with rinc=1 -> rptr=0, raddr=0, rempty=1, rvalid=0, rdata=0x00, rlevel=0, raempty=1, rerr_uflow=0.
REQ-034 rq2_wptr 0000->0001, mem[0]=0xA5 -> next edge rempty=0; following edge rvalid=1, rdata=0xA5, rptr=0001, rempty=1, rlevel=1.
REQ-035 rq2_wptr=1100 (8 words, mem[i]=0x10+i), rinc held 1 -> rdata 0x10..0x17 on consecutive edges, raddr 7->0, rptr ends 1100, then rvalid=0, rempty=1, rlevel=0.
REQ-036 rinc=1 with rvalid=0 -> rptr unchanged, rdata unchanged; rerr_uflow=1 and sticky with macro defined, 0 without.
REQ-037 3 words available, one pop per 2 edges -> rlevel 3,2,1,0, with raempty=0,0,1,1 respectively.
REQ-038 rlevel=5 mid-stream, rrst_n=0 for 1 edge with rinc=1 -> all REQ-030 values on that edge; the stream resumes from rptr=0 after release.
